// File: rtl/counter_stim_gen.sv
// Stimulus master for the dual 64-bit event counter: expands a (Count0, Count1) request
// into Count0 beats of En/!Slt followed by PRESCALE*Count1 beats of En/Slt.
module counter_stim_gen #(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned PRESCALE = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Hold,
  input  logic             Abort,
  input  logic [WIDTH-1:0] Count0,
  input  logic [WIDTH-1:0] Count1,
  output logic             En,
  output logic             Slt,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned SHIFT = $clog2(PRESCALE);
  localparam int unsigned R1W   = WIDTH + SHIFT;

  typedef enum logic [1:0] {IDLE, RUN0, RUN1, FIN} state_t;

  state_t           state;
  logic [WIDTH-1:0] rem0;
  logic [R1W-1:0]   rem1;
  logic [R1W-1:0]   load1;

  // Count1*PRESCALE as a shift into the widened register, so all-ones cannot wrap.
  assign load1 = {Count1, {SHIFT{1'b0}}};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      rem0  <= '0;
      rem1  <= '0;
      En    <= 1'b0;
      Slt   <= 1'b0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          En   <= 1'b0;
          Slt  <= 1'b0;
          Done <= 1'b0;
          if (Start) begin
            rem0 <= Count0;
            rem1 <= load1;
            Busy <= 1'b1;
            if (Count0 != '0)      state <= RUN0;
            else if (Count1 != '0) state <= RUN1;
            else                   state <= FIN;
          end
        end

        RUN0, RUN1: begin
          if (Abort) begin
            En    <= 1'b0;
            Slt   <= 1'b0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
            state <= IDLE;
          end else if (Hold) begin
            En  <= 1'b0;
            Slt <= 1'b0;
          end else begin
            En  <= 1'b1;
            Slt <= (state == RUN1);
            if (state == RUN0) begin
              rem0 <= rem0 - WIDTH'(1);
              // Phase change happens on the last beat edge, so no idle cycle between phases.
              if (rem0 == WIDTH'(1)) state <= (rem1 != '0) ? RUN1 : FIN;
            end else begin
              rem1 <= rem1 - R1W'(1);
              if (rem1 == R1W'(1)) state <= FIN;
            end
          end
        end

        FIN: begin
          En    <= 1'b0;
          Slt   <= 1'b0;
          Busy  <= 1'b0;
          Done  <= ~Abort;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
